fetch_queue: RTL

Instruction fetch stage that sits directly upstream of the behavioral `mem` unit and feeds decode/`rf`. It owns the fetch PC, drives `mem` address/read, captures the combinational `memOut` word, and buffers fetched instructions in a small FIFO. Decode consumes them through a valid/ready handshake. A redirect port, used for branches and jumps, flushes the buffer and restarts fetch at a new PC.

---
 rtl/fetch_queue.sv | 102 ++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, reads the combinational mem port,
// and buffers {pc, ins} pairs in a small circular queue toward decode.
//
// Handshakes: a head entry moves to decode in any cycle where valid=1 and
// ready=1 (pop). valid is held until that happens. A fetch is issued and
// captured in any cycle where memRead=1.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] memAddr,
  output logic        memRead,
  input  logic [31:0] memData,
  input  logic        redirect,
  input  logic [31:0] redirectPc,
  output logic        valid,
  input  logic        ready,
  output logic [31:0] insOut,
  output logic [31:0] pcOut,
  output logic        fault,
  output logic        state_dbg
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t          state;
  logic [31:0]     fetch_pc;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [31:0]     pc_mem  [DEPTH];
  logic [31:0]     ins_mem [DEPTH];

  logic pop;
  logic push;

  // Outputs toward decode depend only on registered state.
  assign valid     = (count != '0);
  assign insOut    = valid ? ins_mem[rd_ptr] : 32'h0;
  assign pcOut     = valid ? pc_mem[rd_ptr]  : 32'h0;
  assign state_dbg = state;

  assign pop     = valid & ready;
  assign push    = rst_n & (state == ST_RUN) & ~redirect & ((count < DEPTH_C) | pop);
  assign memRead = push;
  assign memAddr = fetch_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      fault    <= 1'b0;
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      // Any same-cycle pop is already complete; everything left is dropped.
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      if (redirectPc[1:0] == 2'b00) begin
        fetch_pc <= redirectPc;
        state    <= ST_RUN;
        fault    <= 1'b0;
      end else begin
        state <= ST_HALT;
        fault <= 1'b1;
      end
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PW'(1);
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; count alone decides what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]  <= fetch_pc;
      ins_mem[wr_ptr] <= memData;
    end
  end

endmodule
